// File: rtl/pixel_downscaler.sv
// pixel_downscaler
// Converts an RGB565 DVP pixel stream to 8-bit grayscale and halves the
// resolution in both directions (IMG_W x IMG_H in, IMG_W/2 x IMG_H/2 out).
//
// Optional feature macro: PXL_DSP_AVG_EN
//   defined   -> each output is the rounded average of a horizontal pair
//   undefined -> each output is the even-column pixel; odd columns are dropped
// Odd input rows are always dropped.
//
// Ports:
//   clk, rst      single clock, asynchronous active-high reset
//   dvp_pxl_i     RGB565 pixel {R[4:0], G[5:0], B[4:0]}
//   dvp_sof_i     start of frame, qualified by dvp_vld_i
//   dvp_vld_i     input pixel valid
//   dvp_rdy_o     input pixel ready (combinational, no bubble)
//   pdf_pxl_o     grayscale pixel to the downscaler FIFO
//   pdf_vld_o     output pixel valid
//   pdf_rdy_i     FIFO ready
//   frame_done_o  one-cycle pulse after the last pixel of a frame is accepted
module pixel_downscaler #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int RGB_PXL_W = 16,
  parameter int GS_PXL_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RGB_PXL_W-1:0] dvp_pxl_i,
  input  logic                 dvp_sof_i,
  input  logic                 dvp_vld_i,
  output logic                 dvp_rdy_o,
  output logic [GS_PXL_W-1:0]  pdf_pxl_o,
  output logic                 pdf_vld_o,
  input  logic                 pdf_rdy_i,
  output logic                 frame_done_o
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW} state_t;

  state_t           state, state_nxt;
  logic [COL_W-1:0] col_cnt, col_nxt, eff_col;
  logic [ROW_W-1:0] row_cnt, row_nxt, eff_row;
  logic             in_hsk, active, eff_even, line_end, frame_end;
  logic             load, done_nxt;
  logic [4:0]       r5, b5;
  logic [5:0]       g6;
  logic [7:0]       r8, g8, b8, gray, out_val;
  logic [15:0]      gray_sum;

  // Input may be taken whenever the output register is empty or draining.
  assign dvp_rdy_o = ~pdf_vld_o | pdf_rdy_i;
  assign in_hsk    = dvp_vld_i & dvp_rdy_o;

  // Luma approximation with bit-replicated channel expansion. The weights
  // sum to 256, so the 16-bit sum peaks at 65280 and never overflows.
  always_comb begin
    r5       = dvp_pxl_i[15:11];
    g6       = dvp_pxl_i[10:5];
    b5       = dvp_pxl_i[4:0];
    r8       = {r5, r5[4:2]};
    g8       = {g6, g6[5:4]};
    b8       = {b5, b5[4:2]};
    gray_sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
    gray     = 8'(gray_sum >> 8);
  end

  // Next-state logic. A SOF pixel is treated as row 0, col 0 of an even row
  // regardless of the current state, which gives both the IDLE start and the
  // mid-frame restart from the same path.
  always_comb begin
    state_nxt = state;
    col_nxt   = col_cnt;
    row_nxt   = row_cnt;
    done_nxt  = 1'b0;
    eff_col   = dvp_sof_i ? '0 : col_cnt;
    eff_row   = dvp_sof_i ? '0 : row_cnt;
    eff_even  = dvp_sof_i | (state == EVEN_ROW);
    active    = in_hsk & (dvp_sof_i | (state != IDLE));
    line_end  = (eff_col == COL_W'(IMG_W - 1));
    frame_end = line_end & (eff_row == ROW_W'(IMG_H - 1));
    if (active) begin
      if (frame_end) begin
        col_nxt   = '0;
        row_nxt   = '0;
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else if (line_end) begin
        col_nxt   = '0;
        row_nxt   = ROW_W'(eff_row + 1);
        state_nxt = eff_even ? ODD_ROW : EVEN_ROW;
      end else begin
        col_nxt   = COL_W'(eff_col + 1);
        row_nxt   = eff_row;
        state_nxt = eff_even ? EVEN_ROW : ODD_ROW;
      end
    end
  end

`ifdef PXL_DSP_AVG_EN
  logic [7:0] hold_r;
  logic [8:0] avg_sum;

  // Round-half-up average of the held even-column pixel and the odd one.
  assign avg_sum = {1'b0, hold_r} + {1'b0, gray} + 9'd1;
  assign out_val = 8'(avg_sum >> 1);
  assign load    = active & eff_even & eff_col[0];

  // Even-column gray waits here for its odd-column partner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r <= '0;
    end else if (active & eff_even & ~eff_col[0]) begin
      hold_r <= gray;
    end
  end
`else
  assign out_val = gray;
  assign load    = active & eff_even & ~eff_col[0];
`endif

  // State and position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      state   <= state_nxt;
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
    end
  end

  // Output register: a new load wins over a drain in the same cycle, and the
  // data only changes on a load, so it stays stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdf_pxl_o    <= '0;
      pdf_vld_o    <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      if (load) begin
        pdf_pxl_o <= GS_PXL_W'(out_val);
        pdf_vld_o <= 1'b1;
      end else if (pdf_rdy_i) begin
        pdf_vld_o <= 1'b0;
      end
      frame_done_o <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pixel_downscaler.sv
// tb_pixel_downscaler
// Scoreboard bench for pixel_downscaler on a reduced 16x8 frame. Stimulus
// pushes expected output pixels into a queue; a monitor pops and compares
// each time the DUT hands a pixel to the FIFO side.
module tb_pixel_downscaler;

  localparam int W = 16;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dvp_pxl_i;
  logic        dvp_sof_i;
  logic        dvp_vld_i;
  logic        dvp_rdy_o;
  logic [7:0]  pdf_pxl_o;
  logic        pdf_vld_o;
  logic        pdf_rdy_i;
  logic        frame_done_o;

  int          checks = 0;
  int          fails = 0;
  int          out_count = 0;
  int          done_count = 0;
  bit          rdy_random = 1'b0;
  logic [7:0]  exp_q[$];
  bit          stall_prev = 1'b0;
  logic [7:0]  stall_pxl = 8'd0;

  int          m_col = 0;
  int          m_row = 0;
  bit          m_active = 1'b0;
  int          m_hold = 0;

  pixel_downscaler #(.IMG_W(W), .IMG_H(H), .RGB_PXL_W(16), .GS_PXL_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .dvp_pxl_i    (dvp_pxl_i),
    .dvp_sof_i    (dvp_sof_i),
    .dvp_vld_i    (dvp_vld_i),
    .dvp_rdy_o    (dvp_rdy_o),
    .pdf_pxl_o    (pdf_pxl_o),
    .pdf_vld_o    (pdf_vld_o),
    .pdf_rdy_i    (pdf_rdy_i),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  // FIFO side: either always ready or randomly stalling.
  always @(negedge clk) begin
    pdf_rdy_i = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] model_gray(input logic [15:0] p);
    int r, g, b, r8, g8, b8;
    r  = int'(p[15:11]);
    g  = int'(p[10:5]);
    b  = int'(p[4:0]);
    r8 = (r << 3) | (r >> 2);
    g8 = (g << 2) | (g >> 4);
    b8 = (b << 3) | (b >> 2);
    return 8'((77 * r8 + 150 * g8 + 29 * b8) / 256);
  endfunction

  function automatic logic [15:0] pattern(input int c, input int r);
    return 16'(c * 2113 + r * 997 + 5);
  endfunction

  // Reference model of one accepted input pixel.
  task automatic model_accept(input logic [15:0] p, input bit sof, output bit fe);
    int g;
    fe = 1'b0;
    if (sof) begin
      m_col = 0;
      m_row = 0;
      m_active = 1'b1;
    end
    if (!m_active) return;
    g = int'(model_gray(p));
    if (m_row % 2 == 0) begin
`ifdef PXL_DSP_AVG_EN
      if (m_col % 2 == 0) m_hold = g;
      else exp_q.push_back(8'((m_hold + g + 1) / 2));
`else
      if (m_col % 2 == 0) exp_q.push_back(8'(g));
`endif
    end
    fe = (m_col == W - 1) && (m_row == H - 1);
    if (m_col == W - 1) begin
      m_col = 0;
      m_row++;
    end else begin
      m_col++;
    end
    if (fe) begin
      m_active = 1'b0;
      m_row = 0;
    end
  endtask

  // Offer one pixel (called at a falling edge) until it is accepted.
  task automatic applyStimulus(input logic [15:0] p, input bit sof);
    bit acc = 1'b0;
    bit fe = 1'b0;
    dvp_pxl_i = p;
    dvp_sof_i = sof;
    dvp_vld_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      acc = dvp_rdy_o;
      @(posedge clk);
      if (acc) model_accept(p, sof, fe);
      @(negedge clk);
      if (acc) break;
    end
    dvp_vld_i = 1'b0;
    dvp_sof_i = 1'b0;
    checkOutput("input handshake", 32'(acc), 32'd1);
    if (acc && fe) begin
      #1;
      checkOutput("frame_done timing", 32'(frame_done_o), 32'd1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: sampled a little after the falling edge, well clear of the
  // rising edge, seeing exactly what the next rising edge will act on.
  always @(negedge clk) begin
    logic [7:0] e;
    #2;
    if (!rst) begin
      if (frame_done_o) done_count++;
      if (stall_prev) begin
        checkOutput("stall valid held", 32'(pdf_vld_o), 32'd1);
        checkOutput("stall pixel stable", 32'(pdf_pxl_o), 32'(stall_pxl));
      end
      if (pdf_vld_o && !pdf_rdy_i)
        checkOutput("backpressure ready", 32'(dvp_rdy_o), 32'd0);
      stall_prev = pdf_vld_o & ~pdf_rdy_i;
      stall_pxl  = pdf_pxl_o;
      if (pdf_vld_o && pdf_rdy_i) begin
        out_count++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected output: got %0d, expected no pixel", pdf_pxl_o);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pixel value", 32'(pdf_pxl_o), 32'(e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_out, base_done;
    rst       = 1'b1;
    dvp_pxl_i = '0;
    dvp_sof_i = 1'b0;
    dvp_vld_i = 1'b0;
    pdf_rdy_i = 1'b1;
    idle(3);
    rst = 1'b0;
    #2;
    checkOutput("reset pdf_vld", 32'(pdf_vld_o), 32'd0);
    checkOutput("reset frame_done", 32'(frame_done_o), 32'd0);
    checkOutput("reset dvp_rdy", 32'(dvp_rdy_o), 32'd1);
    checkOutput("reset pdf_pxl", 32'(pdf_pxl_o), 32'd0);
    idle(1);

    // Pixels without SOF in IDLE are dropped.
    for (int i = 0; i < 4; i++) applyStimulus(16'hFFFF, 1'b0);
    idle(3);
    checkOutput("idle no valid", 32'(pdf_vld_o), 32'd0);
    checkOutput("idle no outputs", 32'(out_count), 32'd0);

    // SOF + white pair -> 255.
    applyStimulus(16'hFFFF, 1'b1);
`ifndef PXL_DSP_AVG_EN
    checkOutput("white latency", 32'(pdf_vld_o), 32'd1);
    checkOutput("white value", 32'(pdf_pxl_o), 32'd255);
`endif
    applyStimulus(16'hFFFF, 1'b0);
`ifdef PXL_DSP_AVG_EN
    checkOutput("white latency", 32'(pdf_vld_o), 32'd1);
    checkOutput("white value", 32'(pdf_pxl_o), 32'd255);
`endif

    // Red (76) then green (149) on a restarted row 0.
    applyStimulus(16'hF800, 1'b1);
`ifndef PXL_DSP_AVG_EN
    checkOutput("red/green value", 32'(pdf_pxl_o), 32'd76);
`endif
    applyStimulus(16'h07E0, 1'b0);
`ifdef PXL_DSP_AVG_EN
    checkOutput("red/green value", 32'(pdf_pxl_o), 32'd113);
`endif

    // Blue pair (28) on row 0, then the same pair on row 1 gives nothing.
    applyStimulus(16'h001F, 1'b1);
    applyStimulus(16'h001F, 1'b0);
    checkOutput("blue value", 32'(pdf_pxl_o), 32'd28);
    for (int c = 2; c < W; c++) applyStimulus(16'h0000, 1'b0);
    idle(3);
    base_out = out_count;
    applyStimulus(16'h001F, 1'b0);
    applyStimulus(16'h001F, 1'b0);
    idle(3);
    checkOutput("odd row no valid", 32'(pdf_vld_o), 32'd0);
    checkOutput("odd row no outputs", 32'(out_count - base_out), 32'd0);

    // Full frame with the FIFO always ready.
    base_out  = out_count;
    base_done = done_count;
    for (int i = 0; i < W * H; i++) applyStimulus(pattern(i % W, i / W), i == 0);
    idle(4);
    checkOutput("frame output count", 32'(out_count - base_out), 32'(W * H / 4));
    checkOutput("frame_done pulses", 32'(done_count - base_done), 32'd1);

    // Back in IDLE: non-SOF pixels are dropped.
    base_out = out_count;
    for (int i = 0; i < 4; i++) applyStimulus(16'hFFFF, 1'b0);
    idle(3);
    checkOutput("post-frame idle", 32'(out_count - base_out), 32'd0);

    // Random stalls, SOF injected at row 3, then a complete frame.
    rdy_random = 1'b1;
    base_done  = done_count;
    for (int i = 0; i < 3 * W + 5; i++) applyStimulus(pattern(i % W, i / W) ^ 16'h5A5A, i == 0);
    for (int i = 0; i < W * H; i++) begin
      applyStimulus(pattern(i % W, i / W) ^ 16'h3C3C, i == 0);
      if (i == 1) checkOutput("no done on restart", 32'(done_count - base_done), 32'd0);
    end
    rdy_random = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) idle(1);
    idle(3);
    checkOutput("stall frame_done pulses", 32'(done_count - base_done), 32'd1);
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
